// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud tick generator, frame sequencer and watchdog for uart_rx,
// with a first-word-fall-through byte FIFO on the host side.
module uart_rx_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 868,
  parameter int FIFO_DEPTH  = 4,
  parameter int WDOG_TICKS  = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_div_load,
  input  logic                          rx_line,
  output logic                          enable_clk,
  output logic                          valid,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_ready,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WDOG_TICKS + 1);

  typedef enum logic [1:0] {
    OFF,
    ARMED,
    FRAME
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, cnt_q, pend_q;
  logic             pend_v;
  logic             line_q, rdy_q;
  logic [WW-1:0]    wdog_q;

  logic             tick, start, rdy_edge, timeout;
  logic             push, ferr_set, frame_exit;
  logic             load_now;
  logic [DIV_W-1:0] load_val;

  assign tick = (state_q != OFF) &&
                ((div_q <= DIV_W'(1)) || (cnt_q == div_q - DIV_W'(1)));
  assign start    = line_q & ~rx_line;
  assign rdy_edge = rx_ready & ~rdy_q;
  assign timeout  = (wdog_q == WW'(WDOG_TICKS));

  assign enable_clk = tick;
  assign valid      = (state_q != OFF);
  assign busy       = (state_q == FRAME);

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (!rx_en) begin
      state_d = OFF;
    end else begin
      unique case (state_q)
        OFF:     state_d = ARMED;
        ARMED:   if (start) state_d = FRAME;
        FRAME: begin
          // a byte arriving on the timeout cycle beats the watchdog
          if (rdy_edge) begin
            push    = 1'b1;
            state_d = ARMED;
          end else if (timeout) begin
            ferr_set = 1'b1;
            state_d  = ARMED;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  assign frame_exit = (state_q == FRAME) && (state_d != FRAME);
  assign load_now   = ((state_q != FRAME) && cfg_div_load) ||
                      (frame_exit && (cfg_div_load || pend_v));
  assign load_val   = cfg_div_load ? cfg_div : pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      line_q  <= 1'b1;
      rdy_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= rx_line;
      rdy_q   <= rx_ready;
      if (state_q == ARMED && start)
        wdog_q <= '0;
      else if (state_q == FRAME && tick)
        wdog_q <= wdog_q + WW'(1);
    end
  end

  // divider changes mid-frame are deferred so the current frame keeps its rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_W'(DEFAULT_DIV);
      cnt_q  <= '0;
      pend_q <= '0;
      pend_v <= 1'b0;
    end else begin
      if (load_now) begin
        div_q  <= load_val;
        cnt_q  <= '0;
        pend_v <= 1'b0;
      end else begin
        if (state_q == FRAME && cfg_div_load) begin
          pend_q <= cfg_div;
          pend_v <= 1'b1;
        end
        if (state_q == OFF || tick)
          cnt_q <= '0;
        else
          cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count_q;
  logic          full, pop, wr, ovr_set;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign m_valid = (count_q != '0);
  assign pop     = m_valid && m_ready;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign m_data  = m_valid ? mem[rptr] : 8'h00;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overrun   <= ovr_set  | (overrun   & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed stimulus with a byte scoreboard;
// a negedge monitor checks every FIFO pop against the queue.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, rx_en, cfg_div_load, rx_line;
  logic        rx_ready, m_ready, err_clr;
  logic [15:0] cfg_div;
  logic [7:0]  rx_data, m_data;
  logic        enable_clk, valid, m_valid, busy;
  logic        overrun, frame_err;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];
  logic [7:0] t4 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_en        (rx_en),
    .cfg_div      (cfg_div),
    .cfg_div_load (cfg_div_load),
    .rx_line      (rx_line),
    .enable_clk   (enable_clk),
    .valid        (valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .err_clr      (err_clr)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got %0h expected none", m_data);
      end else begin
        chk("pop_data", {24'h0, m_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_div(int d);
    cfg_div      = 16'(d);
    cfg_div_load = 1'b1;
    step();
    cfg_div_load = 1'b0;
  endtask

  task automatic start_bit();
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
  endtask

  task automatic finish_frame(logic [7:0] b, bit exp_push);
    rx_data  = b;
    rx_ready = 1'b1;
    if (exp_push) sb.push_back(b);
    step();
    rx_ready = 1'b0;
    step();
  endtask

  task automatic measure(string name, int exp);
    int n;
    n = 0;
    while (!enable_clk && n < 40) begin
      step();
      n++;
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!enable_clk && n < 40);
    chk(name, n, exp);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rx_en = 1'b0; cfg_div_load = 1'b0; cfg_div = '0;
    rx_line = 1'b1; rx_ready = 1'b0; rx_data = '0;
    m_ready = 1'b0; err_clr = 1'b0;
    step(2);
    chk("rst_valid", valid, 0);
    chk("rst_enable_clk", enable_clk, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    step();

    // divider rates
    load_div(4);
    chk("t2_off_no_tick", enable_clk, 0);
    rx_en = 1'b1;
    step();
    chk("t2_armed_valid", valid, 1);
    measure("t2_div4", 4);
    load_div(0);
    measure("t2_div0", 1);

    // single frame
    load_div(2);
    m_ready = 1'b1;
    start_bit();
    chk("t3_busy", busy, 1);
    step(2);
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    sb.push_back(8'hA5);
    step();
    chk("t3_m_valid", m_valid, 1);
    chk("t3_m_data", m_data, 8'hA5);
    chk("t3_busy_low", busy, 0);
    rx_ready = 1'b0;
    step(2);
    chk("t3_count", fifo_count, 0);

    // overrun
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start_bit();
      step(2);
      finish_frame(t4[i], i < 4);
    end
    chk("t4_count", fifo_count, 4);
    chk("t4_overrun", overrun, 1);
    chk("t4_head", m_data, 8'h11);
    m_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    step();
    chk("t4_drained", sb.size(), 0);
    chk("t4_count_empty", fifo_count, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_overrun_clr", overrun, 0);

    // watchdog
    start_bit();
    step(20);
    chk("t5_still_busy", busy, 1);
    chk("t5_no_err_yet", frame_err, 0);
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("t5_exit", busy, 0);
    chk("t5_frame_err", frame_err, 1);
    chk("t5_armed", valid, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_err_clr", frame_err, 0);

    // deferred divider load
    start_bit();
    load_div(10);
    measure("t6_pre", 2);
    rx_data  = 8'h3C;
    rx_ready = 1'b1;
    sb.push_back(8'h3C);
    step();
    rx_ready = 1'b0;
    chk("t6_busy_low", busy, 0);
    measure("t6_post", 10);
    chk("t6_no_err", frame_err, 0);
    chk("sb_empty", sb.size(), 0);

    // reset mid-frame with bytes queued
    load_div(2);
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_bit();
      step(2);
      finish_frame(8'h70 + 8'(i), 1'b0);
    end
    start_bit();
    chk("t1_busy", busy, 1);
    chk("t1_count", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    chk("t1_enable_clk", enable_clk, 0);
    chk("t1_valid", valid, 0);
    chk("t1_busy_rst", busy, 0);
    chk("t1_m_valid", m_valid, 0);
    chk("t1_m_data", m_data, 0);
    chk("t1_count_rst", fifo_count, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_frame_err", frame_err, 0);
    step();
    rst_n = 1'b1;
    step(2);
    chk("t1_rearmed", valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
